// File: rtl/sop_pkg.sv
// Shared types and width helpers for the sum_of_products pipeline and its testbenches.
package sop_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } sop_state_t;

  function automatic int sop_sum_width(input int dw);
    return 2 * dw + 2;
  endfunction

endpackage

// File: rtl/sop_window_counter.sv
// Mod-WINDOW sample counter: clear > load-to-1 > increment; flags when the next count reaches WINDOW.
module sop_window_counter #(
  parameter int WINDOW = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic load,
  input  logic inc,
  output logic next_terminal
);

  localparam int CW = $clog2(WINDOW + 1);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;

  always_comb begin
    cnt_next = cnt;
    if (clear) begin
      cnt_next = '0;
    end else if (load) begin
      cnt_next = CW'(1);
    end else if (inc) begin
      cnt_next = (cnt == CW'(WINDOW)) ? CW'(1) : cnt + CW'(1);
    end
  end

  // Looking at the next count lets the FSM leave for HOLD on the same edge the last sample lands.
  assign next_terminal = (cnt_next == CW'(WINDOW));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_next;
    end
  end

endmodule

// File: rtl/sop_window_accumulator.sv
// Sums non-overlapping windows of WINDOW samples and hands each total downstream over valid/ready.
// Define SOP_ACC_PEAK_EN to add out_peak, the largest sample of each window.
module sop_window_accumulator
  import sop_pkg::*;
#(
  parameter int DATA_WIDTH = 4,
  parameter int SUM_WIDTH  = sop_sum_width(DATA_WIDTH),
  parameter int WINDOW     = 4,
  parameter int ACC_WIDTH  = SUM_WIDTH + $clog2(WINDOW)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 in_valid,
  input  logic [SUM_WIDTH-1:0] in_sum,
  output logic                 in_ready,
  output logic                 out_valid,
  output logic [ACC_WIDTH-1:0] out_acc,
`ifdef SOP_ACC_PEAK_EN
  output logic [SUM_WIDTH-1:0] out_peak,
`endif
  input  logic                 out_ready
);

  sop_state_t             state;
  sop_state_t             next_state;
  logic [ACC_WIDTH-1:0]   acc;
  logic                   in_fire;
  logic                   load;
  logic                   inc;
  logic                   next_terminal;

  sop_window_counter #(
    .WINDOW(WINDOW)
  ) u_counter (
    .clk          (clk),
    .rst          (rst),
    .clear        (clear),
    .load         (load),
    .inc          (inc),
    .next_terminal(next_terminal)
  );

  // Handshake decode kept apart from next-state so the counter feedback is not a comb loop.
  always_comb begin
    in_ready = 1'b0;
    load     = 1'b0;
    inc      = 1'b0;
    unique case (state)
      IDLE:    in_ready = 1'b1;
      ACCUM:   in_ready = 1'b1;
      HOLD:    in_ready = out_ready;
      default: in_ready = 1'b0;
    endcase
    if (clear) in_ready = 1'b0;
    in_fire = in_valid & in_ready;
    if (in_fire) begin
      if (state == ACCUM) inc  = 1'b1;
      else                load = 1'b1;
    end
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: begin
        if (in_fire) next_state = next_terminal ? HOLD : ACCUM;
      end
      ACCUM: begin
        if (in_fire && next_terminal) next_state = HOLD;
      end
      HOLD: begin
        if (out_ready) next_state = in_fire ? (next_terminal ? HOLD : ACCUM) : IDLE;
      end
      default: next_state = IDLE;
    endcase
    if (clear) next_state = IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      acc       <= '0;
    end else begin
      state     <= next_state;
      out_valid <= (next_state == HOLD);
      if (clear) begin
        acc <= '0;
      end else if (load) begin
        acc <= ACC_WIDTH'(in_sum);
      end else if (inc) begin
        acc <= acc + ACC_WIDTH'(in_sum);
      end
    end
  end

  assign out_acc = acc;

`ifdef SOP_ACC_PEAK_EN
  logic [SUM_WIDTH-1:0] peak;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      peak <= '0;
    end else if (clear) begin
      peak <= '0;
    end else if (load) begin
      peak <= in_sum;
    end else if (inc && (in_sum > peak)) begin
      peak <= in_sum;
    end
  end

  assign out_peak = peak;
`endif

endmodule

// File: tb/tb_sop_window_accumulator.sv
// Self-checking bench for sop_window_accumulator (DATA_WIDTH=4, WINDOW=4): vector table plus scoreboard.
module tb_sop_window_accumulator;

  localparam int DW  = 4;
  localparam int WIN = 4;
  localparam int SW  = sop_pkg::sop_sum_width(DW);
  localparam int AW  = SW + $clog2(WIN);

  typedef struct packed {
    logic [3:0][SW-1:0] s;
    logic [AW-1:0]      acc;
    logic [SW-1:0]      peak;
  } vec_t;

  typedef struct packed {
    logic [AW-1:0] acc;
    logic [SW-1:0] peak;
  } res_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          clear;
  logic          in_valid;
  logic [SW-1:0] in_sum;
  logic          in_ready;
  logic          out_valid;
  logic [AW-1:0] out_acc;
  logic          out_ready;
`ifdef SOP_ACC_PEAK_EN
  logic [SW-1:0] out_peak;
`endif

  int   checks    = 0;
  int   errors    = 0;
  int   stall_cnt = 0;
  res_t sbq[$];
  res_t exp_res;
  vec_t vecs[7];

  sop_window_accumulator #(
    .DATA_WIDTH(DW),
    .WINDOW    (WIN)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .clear    (clear),
    .in_valid (in_valid),
    .in_sum   (in_sum),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_acc  (out_acc),
`ifdef SOP_ACC_PEAK_EN
    .out_peak (out_peak),
`endif
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, got, want);
    end
  endtask

  function automatic vec_t mk(input int a, input int b, input int c, input int d,
                              input int acc, input int peak);
    vec_t v;
    v.s[0] = SW'(a);
    v.s[1] = SW'(b);
    v.s[2] = SW'(c);
    v.s[3] = SW'(d);
    v.acc  = AW'(acc);
    v.peak = SW'(peak);
    return v;
  endfunction

  function automatic res_t mkres(input int acc, input int peak);
    res_t r;
    r.acc  = AW'(acc);
    r.peak = SW'(peak);
    return r;
  endfunction

  // Offers one sample and returns just after the edge that accepts it; in_valid is left high.
  task automatic send(input logic [SW-1:0] v);
    int w;
    w        = 0;
    in_valid = 1'b1;
    in_sum   = v;
    @(negedge clk);
    while (!in_ready && w < 50) begin
      stall_cnt++;
      w++;
      @(negedge clk);
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles, required 1", w);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_row(input int i);
    for (int k = 0; k < 4; k++) send(vecs[i].s[k]);
    sbq.push_back(mkres(int'(vecs[i].acc), int'(vecs[i].peak)));
    check($sformatf("latency_row%0d", i), 32'(out_valid), 32'd1);
  endtask

  // Scoreboard: every completed handshake must match the oldest expected result.
  always @(negedge clk) begin
    if (rst && out_valid && out_ready) begin
      checks++;
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output: got out_acc=%0d, required no output", out_acc);
      end else begin
        exp_res = sbq.pop_front();
        if (out_acc !== exp_res.acc) begin
          errors++;
          $display("FAIL out_acc: got %0d, required %0d", out_acc, exp_res.acc);
        end
`ifdef SOP_ACC_PEAK_EN
        checks++;
        if (out_peak !== exp_res.peak) begin
          errors++;
          $display("FAIL out_peak: got %0d, required %0d", out_peak, exp_res.peak);
        end
`endif
      end
    end
  end

  initial begin
    vecs[0] = mk(10, 10, 10, 10, 40, 10);
    vecs[1] = mk(1023, 1023, 1023, 1023, 4092, 1023);
    vecs[2] = mk(1, 2, 3, 4, 10, 4);
    vecs[3] = mk(5, 6, 7, 8, 26, 8);
    vecs[4] = mk(3, 9, 2, 7, 21, 9);
    vecs[5] = mk(0, 0, 0, 0, 0, 0);
    vecs[6] = mk(1023, 0, 1023, 1, 2047, 1023);

    rst       = 1'b0;
    clear     = 1'b0;
    in_valid  = 1'b0;
    in_sum    = '0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_out_acc", 32'(out_acc), 32'd0);
    check("reset_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1 rst = 1'b1;

    // Reset mid-window discards the partial sum.
    send(10);
    send(10);
    in_valid = 1'b0;
    rst      = 1'b0;
    #2;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_out_acc", 32'(out_acc), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1 rst = 1'b1;

    // Whole table streamed back to back with the consumer always ready.
    stall_cnt = 0;
    for (int i = 0; i < 7; i++) run_row(i);
    in_valid = 1'b0;
    check("stream_no_stall", 32'(stall_cnt), 32'd0);
    repeat (2) @(posedge clk);
    #1;

    // Backpressure in HOLD with the next sample already waiting.
    out_ready = 1'b0;
    run_row(2);
    in_valid = 1'b1;
    in_sum   = 99;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check($sformatf("bp_out_valid_c%0d", c), 32'(out_valid), 32'd1);
      check($sformatf("bp_out_acc_c%0d", c), 32'(out_acc), 32'd10);
      check($sformatf("bp_in_ready_c%0d", c), 32'(in_ready), 32'd0);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    send(99);
    check("bp_after_fire_out_valid", 32'(out_valid), 32'd0);
    send(1);
    send(1);
    send(1);
    sbq.push_back(mkres(102, 99));
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Clear mid-window.
    send(7);
    send(7);
    in_valid = 1'b0;
    clear    = 1'b1;
    @(posedge clk);
    #1 clear = 1'b0;
    check("clear_out_valid", 32'(out_valid), 32'd0);
    check("clear_out_acc", 32'(out_acc), 32'd0);
    for (int k = 0; k < 4; k++) send(5);
    sbq.push_back(mkres(20, 5));
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Clear while a result is pending drops it.
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) send(2);
    in_valid = 1'b0;
    @(negedge clk);
    check("hold_pending_out_valid", 32'(out_valid), 32'd1);
    @(posedge clk);
    #1 clear = 1'b1;
    @(posedge clk);
    #1 clear = 1'b0;
    check("hold_clear_out_valid", 32'(out_valid), 32'd0);
    out_ready = 1'b1;
    run_row(4);
    in_valid = 1'b0;

    repeat (4) @(negedge clk);
    check("scoreboard_empty", 32'(sbq.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
